cdc_tx_arbiter: RTL

//  Source-domain front end for the multi-bit CDC handshake channel. Shares one

---
 rtl/cdc_tx_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cdc_tx_arbiter.sv
// -----------------------------------------------------------------------------
// cdc_tx_arbiter
//   Source-domain front end of the multi-bit CDC handshake channel. Shares one
//   channel among N_REQ requesters using round-robin arbitration. It captures
//   the winning word and drives the 4-phase vld/ack handshake toward the
//   synchroniser. The block runs entirely in clk_i. sync_ack_i is already
//   synchronised into clk_i.
//
// Parameters
//   N_REQ   number of requesters (>= 2)
//   DW      data word width
//   TO_CYC  ack timeout in clk_i cycles (CDC_ARB_TIMEOUT_EN builds only)
//
// Ports
//   clk_i        source-domain clock
//   rst_i        synchronous reset, active-high
//   req_i        per-requester request level
//   din_i        packed words, requester k at [k*DW +: DW]
//   gnt_o        one-hot 1-cycle pulse: word k captured
//   sync_vld_o   channel valid (4-phase request)
//   sync_dout_o  word to channel, stable while sync_vld_o=1
//   sync_ack_i   channel ack, synchronised to clk_i
//   busy_o       1 while the FSM is outside IDLE
//   err_o        1-cycle pulse on ack timeout
//
// Optional feature macro
//   CDC_ARB_TIMEOUT_EN  enables the WAIT_ACK timeout counter. When this macro
//                       is undefined, WAIT_ACK waits indefinitely and err_o
//                       is tied to 0.
// -----------------------------------------------------------------------------
module cdc_tx_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DW     = 8,
    parameter int TO_CYC = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ*DW-1:0] din_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic               sync_vld_o,
    output logic [DW-1:0]      sync_dout_o,
    input  logic               sync_ack_i,
    output logic               busy_o,
    output logic               err_o
);

    localparam int          PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned NR = N_REQ;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_rr_ptr;
    logic [PW-1:0]     w_rr_ptr_nxt;
    logic [N_REQ-1:0]  w_gnt_nxt;
    logic              w_vld_nxt;
    logic [DW-1:0]     w_dout_nxt;
    logic              w_busy_nxt;

    logic              w_found;
    logic [PW-1:0]     w_winner;
    int unsigned       w_idx;

`ifdef CDC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);
    logic [CW-1:0]     r_to_cnt;
    logic [CW-1:0]     w_to_cnt_nxt;
    logic [CW-1:0]     w_to_cnt_inc;
    logic              w_err_nxt;
`endif

    // Round-robin search: scan from r_rr_ptr upward, wrapping modulo N_REQ.
    // The first requester found wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int unsigned i = 0; i < NR; i++) begin
            w_idx = (int'(r_rr_ptr) + i) % NR;
            if (!w_found && req_i[w_idx]) begin
                w_found  = 1'b1;
                w_winner = PW'(w_idx);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_gnt_nxt    = '0;
        w_vld_nxt    = sync_vld_o;
        w_dout_nxt   = sync_dout_o;
`ifdef CDC_ARB_TIMEOUT_EN
        w_to_cnt_nxt = r_to_cnt;
        w_to_cnt_inc = r_to_cnt + 1'b1;
        w_err_nxt    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_vld_nxt = 1'b0;
                // A still-high ack belongs to the previous handshake and
                // holds off the next launch.
                if (w_found && !sync_ack_i) begin
                    w_gnt_nxt[w_winner] = 1'b1;
                    w_dout_nxt          = din_i[w_winner*DW +: DW];
                    w_vld_nxt           = 1'b1;
                    w_state_nxt         = ST_WAIT_ACK;
                    w_rr_ptr_nxt        = (w_winner == PW'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
`ifdef CDC_ARB_TIMEOUT_EN
                    w_to_cnt_nxt        = '0;
`endif
                end
            end
            ST_WAIT_ACK: begin
                w_vld_nxt = 1'b1;
                if (sync_ack_i) begin
                    w_vld_nxt   = 1'b0;
                    w_state_nxt = ST_WAIT_REL;
                end
`ifdef CDC_ARB_TIMEOUT_EN
                else if (w_to_cnt_inc == CW'(TO_CYC)) begin
                    // Word is dropped. rr_ptr keeps the value it already
                    // advanced to.
                    w_err_nxt    = 1'b1;
                    w_vld_nxt    = 1'b0;
                    w_state_nxt  = ST_WAIT_REL;
                    w_to_cnt_nxt = w_to_cnt_inc;
                end else begin
                    w_to_cnt_nxt = w_to_cnt_inc;
                end
`endif
            end
            ST_WAIT_REL: begin
                w_vld_nxt = 1'b0;
                if (!sync_ack_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_vld_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            gnt_o       <= '0;
            sync_vld_o  <= 1'b0;
            sync_dout_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            gnt_o       <= w_gnt_nxt;
            sync_vld_o  <= w_vld_nxt;
            sync_dout_o <= w_dout_nxt;
            busy_o      <= w_busy_nxt;
        end
    end

`ifdef CDC_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_to_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            r_to_cnt <= w_to_cnt_nxt;
            err_o    <= w_err_nxt;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule
